booth2_final_adder_pipe: RTL and testbench
==========================================

Name: booth2_final_adder_pipe

Overview:
- Final carry-propagate stage of the 16x16 signed Booth-2/Wallace multiplier.
- Sits directly downstream of the 8-to-2 partial-product compressor and consumes its two 2's-complement rows, PP_A (31 bit) and PP_B (29 bit, weight offset 2, low zeros not yet appended).
- Produces the 32-bit signed product through a 2-stage split-carry adder pipeline with valid/ready handshakes on both sides, so the compressor can be stalled by downstream backpressure.

Parameters:
- SPLIT, 16: bit position where the 32-bit addition is cut between stage 1 (bits SPLIT-1:0) and stage 2 (bits 31:SPLIT); legal range 4..28.

Ports:
- sys_clk  input  1  single clock, all state on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- in_valid  input  1  PP_A/PP_B hold a valid pair.
- in_ready  output  1  block accepts a pair this cycle.
- pp_a  input  31  compressed row 1, 2's complement, weight 2^0.
- pp_b  input  29  compressed row 2, 2's complement, weight 2^2 (bit k has weight 2^(k+2)).
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product this cycle.
- product  output  32  signed product.

Behaviour:
- Arithmetic:
  - A = sign-extend pp_a to 32 bits.
  - B = {sign-extend pp_b to 30 bits, 2'b00}.
  - product = (A + B) mod 2^32. No overflow flag; the valid multiplier range guarantees the result fits.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Data is accepted only on transfer. pp_a/pp_b are don't-care when in_valid=0.
- Stage 1 (s1):
  - On input transfer, registers lo_sum = A[SPLIT-1:0] + B[SPLIT-1:0] (SPLIT bits), lo_carry (carry out), A_hi and B_hi (32-SPLIT bits each).
  - s1_valid is set.
- Stage 2 (s2):
  - On advance, registers product = {A_hi + B_hi + lo_carry, lo_sum}.
  - s2_valid is set.
  - out_valid = s2_valid; product is driven directly from the s2 register.
- Advance and ready rules:
  - s2_adv = s1_valid & (!s2_valid | out_ready).
  - in_ready = !s1_valid | s2_adv (combinational; no combinational path from in_valid to in_ready).
  - s2_valid clears on output transfer without s2_adv.
  - s1_valid clears on s2_adv without a new input transfer.
  - Simultaneous s2_adv and input transfer: s1 reloads with the new pair and s1_valid stays 1.
- Timing:
  - Latency: an input transferred in cycle N is presented with out_valid=1 in cycle N+2 when out_ready is held high.
  - Throughput: one product per cycle while out_ready=1.
- Stall:
  - With out_ready=0, out_valid and product hold stable.
  - Once s1 also fills, in_ready=0. Maximum 2 pairs in flight; no pair is lost or duplicated.
- Ordering: strict FIFO order.
- Reset:
  - s1_valid=0, s2_valid=0, out_valid=0, product=32'h0, all data registers 0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight pairs with no output, and takes priority over any transfer in that cycle.

Test Plan:
- Basic add: pp_a=31'h0000_0064, pp_b=29'h0000_0001, out_ready=1 -> two cycles later, product=32'h0000_0068 with out_valid=1 for exactly one cycle.
- Sign extension: pp_a=31'h7FFF_FFFF, pp_b=29'h1FFF_FFFF -> product=32'hFFFF_FFFB (-1 + -4).
- Carry across split: pp_a=31'h0000_FFFF, pp_b=29'h0000_0001 (SPLIT=16) -> product=32'h0001_0003, verifying lo_carry propagation.
- Backpressure: stream 4 pairs back-to-back with out_ready=0 from cycle 1 ->
  - in_ready drops after the 2nd accept.
  - product holds the 1st result.
  - Releasing out_ready yields all 4 results in order with no gaps while in_valid stays high.
- Random regression: 10k random (pp_a, pp_b) pairs with random in_valid/out_ready ->
  - scoreboard matches sext(pp_a) + (sext(pp_b) << 2).
  - End-to-end with the compressor: 16x16 signed products including -32768 * -32768 = 32'h4000_0000.
- Mid-flight reset: assert sys_rst for 1 cycle while s1 and s2 hold valid data -> next cycle out_valid=0, in_ready=1, product=0, and no stale result ever appears.

Source files
------------

// File: rtl/booth2_final_adder_pipe.sv
// Final carry-propagate stage of the 16x16 signed Booth-2 multiplier: adds the two
// compressed rows in a 2-stage split-carry pipeline with valid/ready on both sides.
module booth2_final_adder_pipe #(
  parameter int SPLIT = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] pp_a,
  input  logic [28:0] pp_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product
);

  localparam int HW = 32 - SPLIT;

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // ready never depends on the same side's valid, and data only moves on a transfer.

  logic [31:0]    a_ext;
  logic [31:0]    b_ext;
  logic [SPLIT:0] lo_full;

  logic           s1_valid;
  logic [SPLIT-1:0] lo_sum;
  logic           lo_carry;
  logic [HW-1:0]  a_hi;
  logic [HW-1:0]  b_hi;

  logic           s2_valid;
  logic [31:0]    prod_q;
  logic [HW-1:0]  hi_sum;

  logic           s2_adv;
  logic           in_xfer;

  // pp_b carries weight 2^2, so its two low zero bits are appended here.
  assign a_ext   = {pp_a[30], pp_a};
  assign b_ext   = {pp_b[28], pp_b, 2'b00};
  assign lo_full = {1'b0, a_ext[SPLIT-1:0]} + {1'b0, b_ext[SPLIT-1:0]};
  assign hi_sum  = a_hi + b_hi + {{(HW-1){1'b0}}, lo_carry};

  assign s2_adv    = s1_valid & (!s2_valid | out_ready);
  assign in_ready  = !s1_valid | s2_adv;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = s2_valid;
  assign product   = prod_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_valid <= 1'b0;
      lo_sum   <= '0;
      lo_carry <= 1'b0;
      a_hi     <= '0;
      b_hi     <= '0;
      s2_valid <= 1'b0;
      prod_q   <= '0;
    end else begin
      if (in_xfer) begin
        lo_sum   <= lo_full[SPLIT-1:0];
        lo_carry <= lo_full[SPLIT];
        a_hi     <= a_ext[31:SPLIT];
        b_hi     <= b_ext[31:SPLIT];
      end
      // A simultaneous advance and new accept keeps s1 occupied with the new pair.
      s1_valid <= in_xfer | (s1_valid & !s2_adv);

      if (s2_adv) begin
        prod_q <= {hi_sum, lo_sum};
      end
      s2_valid <= s2_adv | (s2_valid & !out_ready);
    end
  end

endmodule

// File: tb/tb_booth2_final_adder_pipe.sv
// Bench for booth2_final_adder_pipe: directed timing/stall/reset cases plus a random
// regression scored against an arithmetic reference and true 16x16 products.
`timescale 1ns/1ps
module tb_booth2_final_adder_pipe;

  logic        sys_clk;
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] pp_a;
  logic [28:0] pp_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  logic [31:0] exp_q[$];
  logic [31:0] cur_exp;
  int          tests;
  int          fails;
  int          n_acc;
  bit          mon_on;

  booth2_final_adder_pipe #(.SPLIT(16)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pp_a     (pp_a),
    .pp_b     (pp_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference: sign-extended rows, second row weighted by 4
  function automatic logic [31:0] model(input logic [30:0] a, input logic [28:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa + sb * 4);
  endfunction

  // scoreboard: observed at negedge, i.e. the transfer that the next posedge performs
  initial begin
    forever begin
      @(negedge sys_clk);
      if (mon_on) begin
        if (sys_rst) begin
          exp_q.delete();
        end else begin
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_out: got %h with empty scoreboard at %0t", product, $time);
            end else begin
              check("product", product, exp_q.pop_front());
            end
          end
          if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            n_acc++;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic drive_rand();
    pp_a    = 31'($urandom);
    pp_b    = 29'($urandom);
    cur_exp = model(pp_a, pp_b);
  endtask

  // pair built from a true 16x16 product, split so both rows stay in range
  task automatic drive_mul();
    int x;
    int y;
    int p;
    int bb;
    int aa;
    x = int'($urandom_range(0, 65535)) - 32768;
    y = int'($urandom_range(0, 65535)) - 32768;
    p = x * y;
    if (p >= 0) bb = int'($urandom_range(1, 1 << 20));
    else        bb = -int'($urandom_range(1, 1 << 20));
    aa = p - 4 * bb;
    pp_a    = aa[30:0];
    pp_b    = bb[28:0];
    cur_exp = p;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  task automatic send_one(input string tag, input logic [30:0] a, input logic [28:0] b,
                          input logic [31:0] expv);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    pp_a      = a;
    pp_b      = b;
    cur_exp   = expv;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, out_valid, 0);
    @(posedge sys_clk); #1;
    check({tag, "_lat2_valid"}, out_valid, 1);
    check({tag, "_value"}, product, expv);
    @(posedge sys_clk); #1;
    check({tag, "_one_cycle"}, out_valid, 0);
  endtask

  task automatic backpressure();
    logic [30:0] ta[4];
    logic [28:0] tb[4];
    logic [31:0] te[4];
    int k;
    bit acc;
    for (int i = 0; i < 4; i++) begin
      ta[i] = 31'($urandom);
      tb[i] = 29'($urandom);
      te[i] = model(ta[i], tb[i]);
    end
    k = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    pp_a = ta[0]; pp_b = tb[0]; cur_exp = te[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      acc = in_valid && in_ready;
      @(posedge sys_clk); #1;
      if (acc) k++;
      if (k < 4) begin pp_a = ta[k]; pp_b = tb[k]; cur_exp = te[k]; end
    end
    check("bp_accepted", k, 2);
    @(negedge sys_clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_product", product, te[0]);
    @(posedge sys_clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      check("bp_no_gap", out_valid, 1);
      acc = in_valid && in_ready;
      @(posedge sys_clk); #1;
      if (acc) k++;
      in_valid = (k < 4);
      if (k < 4) begin pp_a = ta[k]; pp_b = tb[k]; cur_exp = te[k]; end
    end
    check("bp_all_sent", k, 4);
    @(negedge sys_clk);
    check("bp_drained", out_valid, 0);
  endtask

  task automatic mid_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_rand();
    @(posedge sys_clk); #1;
    drive_rand();
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    check("mr_full_in_ready", in_ready, 0);
    sys_rst   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    drive_rand();
    @(posedge sys_clk); #1;
    sys_rst  = 1'b0;
    in_valid = 1'b0;
    check("mr_out_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_product", product, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk);
      check("mr_no_stale", out_valid, 0);
    end
  endtask

  task automatic regression(input int count);
    int cyc;
    int start;
    cyc   = 0;
    start = n_acc;
    while ((n_acc - start) < count && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) drive_mul();
      else                           drive_rand();
      @(posedge sys_clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("regress_count", n_acc - start, count);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(posedge sys_clk);
    #1;
    check("regress_drain", exp_q.size(), 0);
  endtask

  initial begin
    tests = 0; fails = 0; n_acc = 0; mon_on = 1'b0;
    sys_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    pp_a = '0; pp_b = '0; cur_exp = '0;
    #1 mon_on = 1'b1;
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_product", product, 32'h0);

    send_one("basic", 31'h0000_0064, 29'h0000_0001, 32'h0000_0068);
    send_one("sext",  31'h7FFF_FFFF, 29'h1FFF_FFFF, 32'hFFFF_FFFB);
    send_one("carry", 31'h0000_FFFF, 29'h0000_0001, 32'h0001_0003);
    send_one("mmin",  31'h3FFF_FFFC, 29'h0000_0001, 32'h4000_0000);
    send_one("zero",  31'h0000_0000, 29'h0000_0000, 32'h0000_0000);

    backpressure();
    mid_reset();
    regression(10000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
